// File: rtl/dcache_sram_3.sv
// dcache_sram_3: simple dual-port byte-writable data-cache SRAM.
// One write port, one read port, one clock, read-first, 1-cycle read.
module dcache_sram_3 #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [BE_WIDTH-1:0]   wr_byte_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [DATA_WIDTH-1:0] rd_data_d;
  logic                  wr_ok;

  // Writes are dropped while reset is held; contents are never cleared.
  assign wr_ok = wr_en & ~rst;

  // Read path zeroes under reset, otherwise fetches the addressed word.
  always_comb begin
    rd_data_d = mem_q[rd_addr];
    if (rst) begin
      rd_data_d = '0;
    end
  end

  // Byte-lane masked write; disabled lanes keep their old contents.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      for (int i = 0; i < BE_WIDTH; i++) begin
        if (wr_byte_en[i]) begin
          mem_q[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  // Output register; sampling the array before the write lands gives
  // read-first behaviour on same-address collisions.
  always_ff @(posedge clk) begin
    rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_dcache_sram_3.sv
// tb_dcache_sram_3: randomized and directed checks of dcache_sram_3
// against an array-based reference model of the memory.
module tb_dcache_sram_3;

  localparam int AW    = 9;
  localparam int DW    = 32;
  localparam int BW    = 4;
  localparam int DEPTH = 512;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [BW-1:0] wr_byte_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;

  logic [DW-1:0] model [DEPTH];
  bit            known [DEPTH];
  logic [DW-1:0] exp_rd;
  bit            exp_known;
  int            pass_cnt;
  int            chk_cnt;

  dcache_sram_3 #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .BE_WIDTH  (BW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_byte_en(wr_byte_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of stimulus; exp_rd is what rd_data must show after
  // the edge. The model is updated after the read value is taken, so a
  // same-address read sees the old word.
  task automatic drive(input bit r, input bit we, input int wa,
                       input logic [DW-1:0] wd, input logic [BW-1:0] be,
                       input int ra);
    logic [DW-1:0] w;
    int wai;
    int rai;
    wai = wa % DEPTH;
    rai = ra % DEPTH;
    rst        = r;
    wr_en      = we;
    wr_addr    = AW'(wa);
    wr_data    = wd;
    wr_byte_en = be;
    rd_addr    = AW'(ra);
    if (r) begin
      exp_rd    = '0;
      exp_known = 1'b1;
    end else begin
      exp_rd    = model[rai];
      exp_known = known[rai];
    end
    @(posedge clk);
    #1;
    if (!r && we) begin
      w = model[wai];
      for (int i = 0; i < BW; i++)
        if (be[i]) w[8*i +: 8] = wd[8*i +: 8];
      if (be != '0) begin
        if (be == 4'hF || known[wai]) begin
          model[wai] = w;
          known[wai] = 1'b1;
        end
      end
    end
  endtask

  task automatic test_reset();
    for (int c = 0; c < 20; c++) begin
      drive(1'b1, 1'b1, c, $urandom, 4'hF, c);
      chk_cnt++;
      if (rd_data !== 32'h0)
        $display("FAIL reset cyc%0d: got %h want 00000000", c, rd_data);
      else
        pass_cnt++;
    end
  endtask

  task automatic test_fill();
    int bad;
    bad = 0;
    for (int k = 0; k < DEPTH; k++)
      drive(1'b0, 1'b1, k + 1, 32'hFFFF_FFFF - DW'(k), 4'hF, 0);
    for (int k = 0; k < DEPTH; k++) begin
      drive(1'b0, 1'b0, 0, '0, 4'h0, k + 1);
      chk_cnt++;
      if (rd_data !== 32'hFFFF_FFFF - DW'(k)) begin
        bad++;
        $display("FAIL fill addr%0d: got %h want %h", (k + 1) % DEPTH,
                 rd_data, 32'hFFFF_FFFF - DW'(k));
      end else begin
        pass_cnt++;
      end
    end
    chk_cnt++;
    if (bad !== 0)
      $display("FAIL fill_total: got %0d mismatches want 0", bad);
    else
      pass_cnt++;
  endtask

  task automatic test_byte_en();
    drive(1'b0, 1'b1, 5, 32'h1234_5678, 4'hF, 0);
    drive(1'b0, 1'b1, 5, 32'hAABB_CCDD, 4'b0101, 0);
    drive(1'b0, 1'b0, 0, '0, 4'h0, 5);
    chk_cnt++;
    if (rd_data !== 32'h12BB_56DD)
      $display("FAIL byte_en: got %h want 12bb56dd", rd_data);
    else
      pass_cnt++;
    drive(1'b0, 1'b1, 5, 32'hFFFF_FFFF, 4'h0, 0);
    drive(1'b0, 1'b0, 0, '0, 4'h0, 5);
    chk_cnt++;
    if (rd_data !== 32'h12BB_56DD)
      $display("FAIL zero_be: got %h want 12bb56dd", rd_data);
    else
      pass_cnt++;
  endtask

  task automatic test_collision();
    drive(1'b0, 1'b1, 7, 32'h1111_1111, 4'hF, 0);
    drive(1'b0, 1'b1, 7, 32'h2222_2222, 4'hF, 7);
    chk_cnt++;
    if (rd_data !== 32'h1111_1111)
      $display("FAIL collision_old: got %h want 11111111", rd_data);
    else
      pass_cnt++;
    drive(1'b0, 1'b0, 0, '0, 4'h0, 7);
    chk_cnt++;
    if (rd_data !== 32'h2222_2222)
      $display("FAIL collision_new: got %h want 22222222", rd_data);
    else
      pass_cnt++;
  endtask

  task automatic test_mid_reset();
    drive(1'b0, 1'b1, 3, 32'hCAFE_F00D, 4'hF, 3);
    drive(1'b1, 1'b1, 3, 32'h0, 4'hF, 3);
    chk_cnt++;
    if (rd_data !== 32'h0)
      $display("FAIL mid_reset_zero: got %h want 00000000", rd_data);
    else
      pass_cnt++;
    drive(1'b0, 1'b0, 0, '0, 4'h0, 3);
    chk_cnt++;
    if (rd_data !== 32'hCAFE_F00D)
      $display("FAIL mid_reset_keep: got %h want cafef00d", rd_data);
    else
      pass_cnt++;
  endtask

  task automatic test_random();
    bit r;
    for (int c = 0; c < 400; c++) begin
      r = ($urandom_range(0, 19) == 0);
      drive(r, 1'($urandom), $urandom_range(0, 1023), $urandom,
            4'($urandom), $urandom_range(0, 1023));
      if (exp_known) begin
        chk_cnt++;
        if (rd_data !== exp_rd)
          $display("FAIL random cyc%0d: got %h want %h", c, rd_data, exp_rd);
        else
          pass_cnt++;
      end
    end
  endtask

  task automatic test_back_to_back();
    int a;
    a = $urandom_range(0, DEPTH - 1);
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, 1'b1, a, DW'(c) * 32'h0101_0101, 4'hF, a);
      chk_cnt++;
      if (rd_data !== exp_rd)
        $display("FAIL b2b cyc%0d: got %h want %h", c, rd_data, exp_rd);
      else
        pass_cnt++;
    end
  endtask

  initial begin
    pass_cnt   = 0;
    chk_cnt    = 0;
    rst        = 1'b1;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    wr_byte_en = '0;
    rd_addr    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      model[i] = '0;
      known[i] = 1'b0;
    end
    test_reset();
    test_byte_en();
    test_collision();
    test_mid_reset();
    test_fill();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
